// File: rtl/uart_tx_engine.sv
// UART transmit engine: one word per valid/ready handshake, serialised LSB-first
// as start, DATA_W data bits, optional even/odd parity and one or two stop bits.
module uart_tx_engine #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Per-frame configuration captured at accept; div already clamped to >= 1.
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             par_en;
    logic             par_bit;
    logic             two_stop;
  } cfg_t;

  state_t            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              tx_out_q, tx_out_d;
  logic              done_q, done_d;
  logic              accept;
  logic              bit_end;

  assign accept  = tx_valid && (state_q == IDLE);
  assign bit_end = (baud_q == cfg_q.div - DIV_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      shift_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_out_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_out_q <= tx_out_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    done_d   = 1'b0;
    tx_out_d = 1'b1;

    if (state_q != IDLE)
      baud_d = bit_end ? '0 : baud_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d        = START;
          shift_d        = tx_data;
          baud_d         = '0;
          bit_d          = '0;
          cfg_d.div      = (baud_div == '0) ? DIV_W'(1) : baud_div;
          cfg_d.par_en   = parity_en;
          cfg_d.par_bit  = (^tx_data) ^ parity_odd;
          cfg_d.two_stop = two_stop;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = cfg_q.par_en ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(cfg_q.two_stop)) begin
            bit_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so the start bit begins
    // the cycle right after the handshake edge.
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = cfg_d.par_bit;
      default: tx_out_d = 1'b1;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_out   = tx_out_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: a DATA_W=8 and a DATA_W=5 instance
// sharing clock, reset and configuration inputs.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, two_stop;
  logic [7:0]  d8_data;
  logic        d8_valid, d8_ready, d8_out, d8_busy, d8_done;
  logic [4:0]  d5_data;
  logic        d5_valid, d5_ready, d5_out, d5_busy, d5_done;

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_W(8), .DIV_W(16)) u_dut8 (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .tx_data(d8_data),
    .tx_valid(d8_valid), .tx_ready(d8_ready), .tx_out(d8_out),
    .tx_busy(d8_busy), .tx_done(d8_done)
  );

  uart_tx_engine #(.DATA_W(5), .DIV_W(16)) u_dut5 (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .tx_data(d5_data),
    .tx_valid(d5_valid), .tx_ready(d5_ready), .tx_out(d5_out),
    .tx_busy(d5_busy), .tx_done(d5_done)
  );

  typedef struct {
    logic out;
    logic busy;
    logic done;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected per-cycle line/busy/done for one frame plus its tx_done cycle.
  task automatic push_frame(input logic [8:0] data, input int dw, input int div,
                            input bit pen, input bit podd, input bit two);
    int   eff;
    logic par;
    exp_t e;
    eff    = (div == 0) ? 1 : div;
    par    = podd;
    e.busy = 1'b1;
    e.done = 1'b0;
    e.out  = 1'b0;
    repeat (eff) sb.push_back(e);
    for (int i = 0; i < dw; i++) begin
      e.out = data[i];
      par   = par ^ data[i];
      repeat (eff) sb.push_back(e);
    end
    if (pen) begin
      e.out = par;
      repeat (eff) sb.push_back(e);
    end
    e.out = 1'b1;
    repeat ((two ? 2 : 1) * eff) sb.push_back(e);
    e.busy = 1'b0;
    e.done = 1'b1;
    sb.push_back(e);
  endtask

  task automatic check_cycles(input bit sel5, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      logic o, b, d, r;
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL %s cycle %0d: scoreboard empty, nothing expected", tag, i);
        return;
      end
      e = sb.pop_front();
      o = sel5 ? d5_out   : d8_out;
      b = sel5 ? d5_busy  : d8_busy;
      d = sel5 ? d5_done  : d8_done;
      r = sel5 ? d5_ready : d8_ready;
      if (o !== e.out || b !== e.busy || d !== e.done || r !== !e.busy) begin
        failures++;
        $display("FAIL %s cycle %0d: out/busy/done/ready=%b%b%b%b expected %b%b%b%b",
                 tag, i + 1, o, b, d, r, e.out, e.busy, e.done, !e.busy);
      end
    end
  endtask

  task automatic accept_word(input bit sel5, input logic [8:0] data, input bit hold,
                             input string tag);
    bit ok;
    ok = 1'b0;
    if (sel5) begin d5_data = data[4:0]; d5_valid = 1'b1; end
    else      begin d8_data = data[7:0]; d8_valid = 1'b1; end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = sel5 ? d5_ready : d8_ready;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s handshake: tx_ready=0 expected 1 within 200 cycles", tag);
    end
    @(posedge clk);
    #1;
    if (!hold) begin d5_valid = 1'b0; d8_valid = 1'b0; end
  endtask

  task automatic check_idle(input bit sel5, input string tag);
    logic o, b, d, r;
    o = sel5 ? d5_out   : d8_out;
    b = sel5 ? d5_busy  : d8_busy;
    d = sel5 ? d5_done  : d8_done;
    r = sel5 ? d5_ready : d8_ready;
    checks++;
    if (o !== 1'b1 || b !== 1'b0 || d !== 1'b0 || r !== 1'b1) begin
      failures++;
      $display("FAIL %s: out/busy/done/ready=%b%b%b%b expected 1001", tag, o, b, d, r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle(1'b0, "reset_dut8");
    check_idle(1'b1, "reset_dut5");
    reset = 1'b1;
    @(negedge clk);
    check_idle(1'b0, "post_reset_dut8");
  endtask

  task automatic test_basic();
    baud_div = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    push_frame(9'h0A5, 8, 4, 1'b0, 1'b0, 1'b0);
    accept_word(1'b0, 9'h0A5, 1'b0, "basic");
    check_cycles(1'b0, 41, "basic_8n1");
  endtask

  task automatic test_parity();
    baud_div = 16'd4; parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
    push_frame(9'h0A5, 8, 4, 1'b1, 1'b0, 1'b0);
    accept_word(1'b0, 9'h0A5, 1'b0, "parity_even");
    check_cycles(1'b0, 45, "parity_even_a5");
    parity_odd = 1'b1;
    push_frame(9'h0A5, 8, 4, 1'b1, 1'b1, 1'b0);
    accept_word(1'b0, 9'h0A5, 1'b0, "parity_odd");
    // Mid-frame config edits must not reach the frame in flight.
    parity_odd = 1'b0; parity_en = 1'b0; two_stop = 1'b1; baud_div = 16'd2;
    check_cycles(1'b0, 45, "parity_odd_a5");
    baud_div = 16'd4; parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
    push_frame(9'h007, 8, 4, 1'b1, 1'b0, 1'b0);
    accept_word(1'b0, 9'h007, 1'b0, "parity_07");
    check_cycles(1'b0, 45, "parity_even_07");
  endtask

  task automatic test_two_stop_div0();
    baud_div = 16'd0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1;
    push_frame(9'h000, 8, 0, 1'b0, 1'b0, 1'b1);
    accept_word(1'b0, 9'h000, 1'b0, "div0");
    check_cycles(1'b0, 12, "two_stop_div0");
    baud_div = 16'd1;
    push_frame(9'h000, 8, 1, 1'b0, 1'b0, 1'b1);
    accept_word(1'b0, 9'h000, 1'b0, "div1");
    check_cycles(1'b0, 12, "two_stop_div1");
  endtask

  task automatic test_back_to_back();
    baud_div = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    push_frame(9'h055, 8, 4, 1'b0, 1'b0, 1'b0);
    push_frame(9'h0AA, 8, 8, 1'b0, 1'b0, 1'b0);
    accept_word(1'b0, 9'h055, 1'b1, "b2b_first");
    d8_data  = 8'hAA;
    baud_div = 16'd8;
    check_cycles(1'b0, 41, "b2b_frame1");
    @(posedge clk);
    #1;
    d8_valid = 1'b0;
    check_cycles(1'b0, 81, "b2b_frame2");
  endtask

  task automatic test_reset_mid_frame();
    baud_div = 16'd4; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    accept_word(1'b0, 9'h0A5, 1'b0, "midrst");
    repeat (18) @(negedge clk);
    checks++;
    if (d8_out !== 1'b0 || d8_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_bit3: out/busy=%b%b expected 01", d8_out, d8_busy);
    end
    #1 reset = 1'b0;
    #1 check_idle(1'b0, "midrst_async");
    @(negedge clk);
    check_idle(1'b0, "midrst_held");
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_idle(1'b0, "midrst_no_done");
    end
    push_frame(9'h03C, 8, 4, 1'b0, 1'b0, 1'b0);
    accept_word(1'b0, 9'h03C, 1'b0, "midrst_next");
    check_cycles(1'b0, 41, "midrst_next_frame");
  endtask

  task automatic test_data_w5();
    baud_div = 16'd2; parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
    push_frame(9'h01F, 5, 2, 1'b1, 1'b0, 1'b0);
    accept_word(1'b1, 9'h01F, 1'b0, "w5_1f");
    check_cycles(1'b1, 17, "w5_1f_even");
    baud_div = 16'd1; parity_odd = 1'b1; two_stop = 1'b1;
    push_frame(9'h00A, 5, 1, 1'b1, 1'b1, 1'b1);
    accept_word(1'b1, 9'h00A, 1'b0, "w5_0a");
    check_cycles(1'b1, 10, "w5_0a_odd_2stop");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [8:0] w;
      int         dv, n;
      bit         pe, po, ts;
      w  = 9'($urandom_range(0, 255));
      dv = $urandom_range(0, 5);
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      ts = 1'($urandom_range(0, 1));
      baud_div = 16'(dv); parity_en = pe; parity_odd = po; two_stop = ts;
      push_frame(w, 8, dv, pe, po, ts);
      n = sb.size();
      accept_word(1'b0, w, 1'b0, "random");
      check_cycles(1'b0, n, "random_frame");
    end
  endtask

  initial begin
    reset = 1'b0; baud_div = '0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    d8_data = '0; d8_valid = 1'b0; d5_data = '0; d5_valid = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_two_stop_div0();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_w5();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
